// File: rtl/ibus_sram_resp.sv
// Instruction-bus SRAM responder: fixed-latency single-outstanding reads with
// address-fault reporting and a backdoor load port.
package common_pkg;
  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;
endpackage

module ibus_sram_resp
  import common_pkg::*;
#(
  parameter int          MEM_WORDS = 4096,
  parameter int          LATENCY   = 2,
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  ibus_req_t                    ireq,
  output ibus_resp_t                   iresp,
  input  logic                         load_en,
  input  logic [$clog2(MEM_WORDS)-1:0] load_idx,
  input  logic [31:0]                  load_data,
  output logic                         err,
  output logic                         busy
);
  localparam int          IDX_W = $clog2(MEM_WORDS);
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  count;
  logic [63:0] addr_q;
  logic        data_ok_q;
  logic        err_q;
  logic [31:0] data_q;

  logic [31:0] mem [MEM_WORDS];

  logic        accept;
  logic        enter_resp;
  logic [63:0] rd_addr;
  logic [63:0] rd_word;
  logic        rd_fault;

  // Reset masks the combinational accept so addr_ok is low while rst is held.
  assign accept     = (state == IDLE) && ireq.valid && !rst;
  assign enter_resp = (accept && LATENCY == 1) || (state == WAIT && count == 4'd1);

  // With LATENCY=1 the read happens on the accept edge, before addr_q is valid.
  assign rd_addr  = (state == IDLE) ? ireq.addr : addr_q;
  assign rd_word  = (rd_addr - BASE_ADDR) >> 2;
  assign rd_fault = (rd_addr[1:0] != 2'b00) || (rd_addr < BASE_ADDR) ||
                    (rd_word >= 64'(MEM_WORDS));

  always_ff @(posedge clk) begin
    if (load_en) mem[load_idx] <= load_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      addr_q    <= '0;
      data_ok_q <= 1'b0;
      err_q     <= 1'b0;
      data_q    <= '0;
    end else begin
      data_ok_q <= 1'b0;
      err_q     <= 1'b0;
      // Nonblocking read of mem sees the pre-write word on a load collision.
      if (enter_resp) begin
        data_ok_q <= 1'b1;
        err_q     <= rd_fault;
        data_q    <= rd_fault ? NOP : mem[rd_word[IDX_W-1:0]];
      end
      case (state)
        IDLE: begin
          if (ireq.valid) begin
            addr_q <= ireq.addr;
            count  <= 4'(LATENCY - 1);
            state  <= (LATENCY == 1) ? RESP : WAIT;
          end
        end
        WAIT: begin
          count <= count - 4'd1;
          if (count == 4'd1) state <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign iresp = {accept, data_ok_q, data_q};
  assign err   = err_q;
  assign busy  = (state != IDLE);
endmodule

// File: doc/ibus_sram_resp.md
IBUS_SRAM_RESP -- requirements
Module: ibus_sram_resp

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 4096, meaning the number of 32-bit instruction words stored; power of two.
REQ-002 SHALL have parameter LATENCY, default 2, meaning cycles from request accept to data_ok; legal range 1..8.
REQ-003 SHALL have parameter BASE_ADDR, default 64'h8000_0000, meaning the byte address of word 0.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port ireq, input, ibus_req_t (common package): uses fields valid and addr[63:0].
REQ-007 SHALL have port iresp, output, ibus_resp_t (common package): drives fields addr_ok, data_ok and data[31:0].
REQ-008 SHALL have port load_en, input, 1 bit: backdoor write strobe.
REQ-009 SHALL have port load_idx, input, $clog2(MEM_WORDS) bits: backdoor word index.
REQ-010 SHALL have port load_data, input, 32 bits: backdoor write data.
REQ-011 SHALL have port err, output, 1 bit: qualifies the current data_ok beat as an address fault.
REQ-012 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-013 SHALL implement states IDLE, WAIT and RESP.
REQ-014 In IDLE with ireq.valid=1, SHALL drive iresp.addr_ok=1 combinationally in that cycle.
REQ-015 On that accept, SHALL latch ireq.addr and load the down-counter with LATENCY-1.
REQ-016 On accept, SHALL go to RESP when LATENCY=1 and to WAIT otherwise.
REQ-017 In WAIT, SHALL decrement the counter each cycle and go to RESP on the edge where it reaches 0.
REQ-018 data_ok SHALL therefore assert exactly LATENCY cycles after the accept cycle.
REQ-019 In RESP, SHALL drive iresp.data_ok=1 for exactly one cycle with registered data and err, then go to IDLE.
REQ-020 SHALL leave one idle cycle after RESP; a request present in the cycle after RESP is accepted in that cycle.
REQ-021 SHALL hold addr_ok=0 outside IDLE.
REQ-022 SHALL ignore changes to ireq.addr or ireq.valid while in WAIT or RESP; the latched address is served.
REQ-023 A valid drop mid-transaction SHALL still produce the data_ok beat.
REQ-024 SHALL compute word index as (latched_addr - BASE_ADDR) >> 2, with 64-bit unsigned subtraction.
REQ-025 Fault condition: latched_addr[1:0] != 0, latched_addr < BASE_ADDR, or index >= MEM_WORDS.
REQ-026 On a fault, the data_ok beat SHALL carry err=1 and data=32'h0000_0013 (RISC-V nop), with no memory read.
REQ-027 SHALL register the memory read on the edge entering RESP.
REQ-028 On an index collision, SHALL return the old word when a load_en write hits the same index on that same edge (read-before-write).
REQ-029 load_en SHALL write load_data to mem[load_idx] on any clock edge, in any state, independent of the bus.
REQ-030 Outside RESP, data SHALL hold its last value and err SHALL be 0.

Reset
REQ-031 rst=1 SHALL immediately force state=IDLE, counter=0, addr_ok=0, data_ok=0, data=32'h0, err=0, busy=0.
REQ-032 rst asserted in WAIT or RESP SHALL drop the pending transaction with no data_ok after reset release.
REQ-033 Reset SHALL NOT clear memory contents.
REQ-034 The first request accept SHALL be possible in the first cycle after rst deasserts.

Verification
REQ-035 Default params; load mem[0]=32'h0010_0093; hold valid, addr=64'h8000_0000 -> addr_ok in cycle 0, data_ok with data=32'h0010_0093 and err=0 in cycle 2, busy high in cycles 1-2.
REQ-036 LATENCY=1 -> data_ok in cycle 1; two back-to-back requests to 0x8000_0000 and 0x8000_0004 -> second addr_ok 2 cycles after first, with correct words returned.
REQ-037 Faults: addr 64'h8000_0002, then 64'h7FFF_FFFC, then BASE_ADDR+4*MEM_WORDS -> each gets data_ok with err=1 and data=32'h0000_0013.
REQ-038 Change addr from 0x8000_0000 to 0x8000_0008 in the cycle after accept -> response carries mem[0].
REQ-039 load_en to index 0 with 32'hDEAD_BEEF on the edge entering RESP for a read of index 0 -> old word returned; next read of index 0 returns 32'hDEAD_BEEF.
REQ-040 Assert rst in WAIT -> all outputs 0 immediately, no data_ok after release, and a fresh request is accepted in the first post-reset cycle.
